// File: rtl/somador_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package somador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOMA = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_PADRAO = 8;

endpackage

// File: rtl/somador_completo.sv
// Combinational full adder built from two half adders plus an OR of their carries.
module somador_completo (
  output logic S,
  output logic Cout,
  input  logic A,
  input  logic B,
  input  logic Cin
);

  logic s_parcial;
  logic c_primeiro;
  logic c_segundo;

  somador_meio meio_ab (
    .S (s_parcial),
    .C (c_primeiro),
    .A (A),
    .B (B)
  );

  somador_meio meio_cin (
    .S (S),
    .C (c_segundo),
    .A (s_parcial),
    .B (Cin)
  );

  assign Cout = c_primeiro | c_segundo;

endmodule

// File: rtl/somador_meio.sv
// Half adder: the basic cell the full adder is composed from.
module somador_meio (
  output logic S,
  output logic C,
  input  logic A,
  input  logic B
);

  assign S = A ^ B;
  assign C = A & B;

endmodule

// File: rtl/somador_serial.sv
// Bit-serial adder: operands accepted by valid/ready, added LSB-first one bit per
// clock on a single full adder, result held on a valid/ready output port.
module somador_serial
  import somador_pkg::*;
#(
  parameter int WIDTH = WIDTH_PADRAO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [CW-1:0]    count;

  logic             bit_soma;
  logic             carry_next;
  logic [WIDTH-1:0] a_shift;

  somador_completo celula (
    .S    (bit_soma),
    .Cout (carry_next),
    .A    (a_reg[0]),
    .B    (b_reg[0]),
    .Cin  (carry)
  );

  // a_reg doubles as the sum register: sum bits enter at the top while the
  // still-unread operand bits move down toward bit 0.
  always_comb begin
    a_shift            = a_reg >> 1;
    a_shift[WIDTH-1]   = bit_soma;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= 1'b0;
            count <= '0;
            state <= SOMA;
          end
        end
        SOMA: begin
          carry <= carry_next;
          a_reg <= a_shift;
          b_reg <= b_reg >> 1;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = a_reg;
  assign cout      = carry;

endmodule

// File: tb/tb_somador_serial.sv
// Directed self-checking bench for somador_serial at WIDTH=8 and WIDTH=1.
module tb_somador_serial;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] sum;
  logic       cout;

  // WIDTH=1 instance
  logic       rst1 = 1'b1;
  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       out_valid1;
  logic       out_ready1 = 1'b0;
  logic [0:0] sum1;
  logic       cout1;

  int checks = 0;
  int errors = 0;

  somador_serial #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  somador_serial #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Drives one accept; returns at the negedge after the accept edge.
  task automatic start_op(input logic [7:0] va, input logic [7:0] vb);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("start_ready", 32'(in_ready), 32'd1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("consume_out_valid", 32'(out_valid), 32'd0);
    check("consume_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run(input logic [7:0] va, input logic [7:0] vb,
                     input logic [7:0] es, input logic ec);
    int cyc;
    start_op(va, vb);
    wait_done(cyc);
    check("latency", 32'(cyc), 32'd8);
    check("sum", 32'(sum), 32'(es));
    check("cout", 32'(cout), 32'(ec));
    consume();
  endtask

  initial begin
    int   cyc;
    logic stable;
    logic [7:0] held_sum;
    logic held_cout;

    // Reset state while rst is held
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);

    // Basic additions
    run(8'h5A, 8'h3C, 8'h96, 1'b0);

    // Overflow with backpressure
    start_op(8'hFF, 8'h01);
    wait_done(cyc);
    check("bp_latency", 32'(cyc), 32'd8);
    check("bp_sum", 32'(sum), 32'h00);
    check("bp_cout", 32'(cout), 32'd1);
    held_sum  = sum;
    held_cout = cout;
    stable    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || sum !== held_sum || cout !== held_cout || in_ready) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    consume();

    run(8'hFF, 8'hFF, 8'hFE, 1'b1);

    // in_valid during SOMA/DONE must be ignored; out_ready outside DONE has no effect
    start_op(8'h12, 8'h34);
    a = 8'hFF;
    b = 8'hFF;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("busy_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b0;
    wait_done(cyc);
    check("ign_latency", 32'(cyc + 1), 32'd8);
    check("ign_sum", 32'(sum), 32'h46);
    check("ign_cout", 32'(cout), 32'd0);
    in_valid = 1'b0;
    consume();
    @(posedge clk);
    @(negedge clk);
    check("ign_idle", 32'(out_valid), 32'd0);

    // Asynchronous reset during SOMA cycle 4
    start_op(8'hAA, 8'h55);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(8'h01, 8'h02, 8'h03, 1'b0);

    // WIDTH=1: exactly one SOMA cycle
    a1 = 1'b1;
    b1 = 1'b1;
    in_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    check("w1_in_ready_busy", 32'(in_ready1), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("w1_out_valid", 32'(out_valid1), 32'd1);
    check("w1_sum", 32'(sum1), 32'd0);
    check("w1_cout", 32'(cout1), 32'd1);
    out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready1 = 1'b0;
    check("w1_consumed", 32'(out_valid1), 32'd0);
    check("w1_in_ready", 32'(in_ready1), 32'd1);
    a1 = 1'b1;
    b1 = 1'b0;
    in_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("w1_sum_b", 32'(sum1), 32'd1);
    check("w1_cout_b", 32'(cout1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
